// File: rtl/rr_rotate_arbiter.sv
// Round-robin N-way arbiter built around a circular barrel shifter.
// The priority pointer doubles as the shift amount for a downstream rotator,
// and the registered grant is handed out over a valid/ready handshake.

// Right barrel shifter; CIRC = 1 rotates, CIRC = 0 shifts in zeros.
module barrel_shift_dir0 #(
  parameter int W    = 8,
  parameter bit CIRC = 1'b1,
  localparam int SW  = $clog2(W)
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] shamt,
  output logic [W-1:0]  result
);

  // Log-depth shift: stage s moves the word by 2**s when shamt[s] is set.
  always_comb begin
    // NOTE: blocking assignments are right here because each stage feeds the next within one evaluation.
    result = data;
    for (int s = 0; s < SW; s++) begin
      if (shamt[s]) begin
        if (CIRC) result = (result >> (1 << s)) | (result << (W - (1 << s)));
        else      result = result >> (1 << s);
      end
    end
  end

endmodule

module rr_rotate_arbiter #(
  parameter int  N     = 8,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             flush,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_onehot,
  output logic [PTR_W-1:0] gnt_idx,
  output logic [PTR_W-1:0] ptr
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state, state_next;
  logic               valid_next;
  logic [N-1:0]       onehot_next;
  logic [PTR_W-1:0]   idx_next;
  logic [PTR_W-1:0]   ptr_next;

  // Arbitration inputs: the live request vector and the scan start position.
  logic [N-1:0]       arb_vec;
  logic [PTR_W-1:0]   arb_ptr;
  logic [N-1:0]       rotated;
  logic [PTR_W-1:0]   lowest;
  logic [PTR_W-1:0]   winner;
  logic               any;
  logic [PTR_W-1:0]   idx_after;

  assign idx_after = gnt_idx + PTR_W'(1);

  // In HOLD the search pre-computes the post-handshake arbitration: the
  // current winner is masked out and the scan starts just past it.
  always_comb begin
    arb_vec = req;
    arb_ptr = ptr;
    if (state == HOLD) begin
      arb_vec = req & ~gnt_onehot;
      arb_ptr = idx_after;
    end
  end

  // Bring the pointer position to bit 0 so a plain lowest-bit search suffices.
  barrel_shift_dir0 #(
    .W    (N),
    .CIRC (1'b1)
  ) u_rotate (
    .data   (arb_vec),
    .shamt  (arb_ptr),
    .result (rotated)
  );

  // Lowest set bit of the rotated vector, then undo the rotation.
  always_comb begin
    lowest = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) lowest = PTR_W'(i);
    end
  end

  // N is a power of two, so the PTR_W-bit add wraps modulo N for free.
  assign winner = lowest + arb_ptr;
  assign any    = |arb_vec;

  // Next-state and next-grant decision; flush overrides everything but reset.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next  = state;
    valid_next  = gnt_valid;
    onehot_next = gnt_onehot;
    idx_next    = gnt_idx;
    ptr_next    = ptr;

    if (flush) begin
      state_next  = IDLE;
      valid_next  = 1'b0;
      onehot_next = '0;
    end else begin
      unique case (state)
        IDLE: begin
          valid_next  = 1'b0;
          onehot_next = '0;
          if (any) begin
            state_next  = HOLD;
            valid_next  = 1'b1;
            idx_next    = winner;
            onehot_next = N'(1) << winner;
          end
        end
        HOLD: begin
          // Without ready the grant is frozen, whatever req does.
          if (gnt_ready) begin
            ptr_next = idx_after;
            if (any) begin
              idx_next    = winner;
              onehot_next = N'(1) << winner;
            end else begin
              state_next  = IDLE;
              valid_next  = 1'b0;
              onehot_next = '0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and grant registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
    if (!reset) begin
      state      <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
      ptr        <= '0;
    end else begin
      state      <= state_next;
      gnt_valid  <= valid_next;
      gnt_onehot <= onehot_next;
      gnt_idx    <= idx_next;
      ptr        <= ptr_next;
    end
  end

endmodule

// File: tb/tb_rr_rotate_arbiter.sv
// Directed testbench for rr_rotate_arbiter (N = 8) with hand-computed expectations.

module tb_rr_rotate_arbiter;

  localparam int N     = 8;
  localparam int PTR_W = 3;

  logic             clock;
  logic             reset;
  logic [N-1:0]     req;
  logic             flush;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [N-1:0]     gnt_onehot;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr;

  int checks = 0;
  int errors = 0;

  rr_rotate_arbiter #(.N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .flush      (flush),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .ptr        (ptr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic v, input int idx, input int p);
    logic [N-1:0] oh;
    oh = v ? (N'(1) << idx) : '0;
    check({tag, ".valid"},  32'(gnt_valid),  32'(v));
    check({tag, ".onehot"}, 32'(gnt_onehot), 32'(oh));
    if (v) check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    check({tag, ".ptr"},    32'(ptr),        32'(p));
  endtask

  initial begin
    reset = 1'b0; req = 8'hFF; flush = 1'b0; gnt_ready = 1'b0;

    // Reset held two cycles with requests pending.
    step(); check_grant("rst0", 1'b0, 0, 0);
    step(); check_grant("rst1", 1'b0, 0, 0);
    check("rst1.idx", 32'(gnt_idx), 32'd0);

    reset = 1'b1;
    step(); check_grant("first", 1'b1, 0, 0);

    // Rotation: all requesting, consumer always ready -> one grant per cycle.
    gnt_ready = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      step(); check_grant($sformatf("rot%0d", j), 1'b1, j % 8, j % 8);
    end

    // Retire idx 5 with nobody requesting: ptr = 6, back to IDLE.
    req = 8'h00;
    step(); check_grant("drain", 1'b0, 0, 6);

    // Wrap: scan 6,7,0 picks requester 0.
    req = 8'b0010_0001; gnt_ready = 1'b0;
    step(); check_grant("wrap", 1'b1, 0, 6);
    gnt_ready = 1'b1;
    step(); check_grant("wrap.next", 1'b1, 5, 1);

    // Backpressure on idx 3.
    req = 8'h08;
    step(); check_grant("bp.load", 1'b1, 3, 6);
    gnt_ready = 1'b0;
    req = 8'hF0; step(); check_grant("bp0", 1'b1, 3, 6);
    req = 8'h00; step(); check_grant("bp1", 1'b1, 3, 6);
    req = 8'hF0; step(); check_grant("bp2", 1'b1, 3, 6);
    req = 8'h00; gnt_ready = 1'b1;
    step(); check_grant("bp.release", 1'b0, 0, 4);

    // Sole requester: granted every other cycle.
    req = 8'h10;
    step(); check_grant("sole0", 1'b1, 4, 4);
    step(); check_grant("sole1", 1'b0, 0, 5);
    step(); check_grant("sole2", 1'b1, 4, 5);
    step(); check_grant("sole3", 1'b0, 0, 5);

    // Flush beats a simultaneous handshake.
    req = 8'h04; gnt_ready = 1'b0;
    step(); check_grant("fl.load", 1'b1, 2, 5);
    flush = 1'b1; gnt_ready = 1'b1;
    step(); check_grant("fl.drop", 1'b0, 0, 5);
    flush = 1'b0; gnt_ready = 1'b0;
    step(); check_grant("fl.regrant", 1'b1, 2, 5);

    // Reset mid-grant drops it with no handshake.
    reset = 1'b0;
    step(); check_grant("rst.mid", 1'b0, 0, 0);
    check("rst.mid.idx", 32'(gnt_idx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_rotate_arbiter.md
Name: rr_rotate_arbiter

Overview:
- Round-robin N-way arbiter placed directly upstream of a circular barrel shifter.
- Its priority pointer drives the shifter's shift amount, and the shifter rotates the request vector so the current pointer position sits at bit 0.
- It selects one requester per transfer and hands the registered grant to the consumer (issue/retire port) over a valid/ready handshake.
- The pointer advances past each accepted winner, so every requester is guaranteed service within N transfers.

Parameters:
- N, 8, number of requesters; power of 2, N >= 2.
- PTR_W, $clog2(N), pointer/index width; derived, not overridden.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clock).
- req  input  N  request vector; bit i = requester i wants a slot.
- flush  input  1  squash: drop any held grant, return to IDLE.
- gnt_ready  input  1  consumer accepts the grant this cycle.
- gnt_valid  output  1  registered grant is valid.
- gnt_onehot  output  N  one-hot grant; all zero when gnt_valid = 0.
- gnt_idx  output  PTR_W  binary index of the granted requester.
- ptr  output  PTR_W  current highest-priority index; this is the shift amount for the downstream rotator.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset values (reset = 0 at a posedge): gnt_valid = 0, gnt_onehot = 0, gnt_idx = 0, ptr = 0, state = IDLE. A reset mid-grant drops the grant with no handshake.
- Winner computation is combinational from the arbitration vector V and pointer P:
  - Rotate V right circularly by P, using barrel_shift_dir0 with CIRC = 1.
  - Priority-encode the lowest set bit k.
  - winner = (k + P) mod N, i.e. the first set bit at index >= P, wrapping past N-1 to 0.
  - Any = |V.
- State IDLE:
  - V = req, P = ptr.
  - If Any: register winner into gnt_idx/gnt_onehot, set gnt_valid = 1, go to HOLD.
  - Otherwise stay in IDLE with outputs zero.
  - Latency: req asserted in cycle t gives gnt_valid = 1 in cycle t+1.
- State HOLD:
  - While gnt_ready = 0, gnt_idx, gnt_onehot and ptr hold stable regardless of req changes. No re-arbitration; the grant is not revoked even if the winner drops req.
- Handshake (HOLD and gnt_ready = 1):
  - ptr <= (gnt_idx + 1) mod N.
  - Same-cycle re-arbitration with V = req & ~gnt_onehot and P = (gnt_idx + 1) mod N.
  - If Any: load the new winner, stay in HOLD, gnt_valid stays 1. This gives back-to-back grants, one per cycle.
  - Else: gnt_valid <= 0, gnt_onehot <= 0, go to IDLE.
- The masking rule means a sole requester cannot be re-granted in the cycle after its handshake. It is granted at most every other cycle.
- flush has highest priority over everything except reset:
  - gnt_valid <= 0, gnt_onehot <= 0, state <= IDLE, ptr unchanged.
  - This holds even if gnt_ready = 1 in the same cycle; the transfer is discarded.
- gnt_ready is ignored in IDLE.
- Invariants:
  - gnt_onehot is one-hot exactly when gnt_valid = 1.
  - gnt_onehot == (1 << gnt_idx) whenever valid.
  - ptr changes only on a non-flushed handshake.
- Fairness: with req held all ones and gnt_ready = 1, each index is granted exactly once per N consecutive grants.

Test Plan:
- Reset, N = 8: hold reset = 0 for 2 cycles with req = 8'hFF -> gnt_valid = 0, ptr = 0 throughout. After release, next cycle gnt_valid = 1, gnt_idx = 0, gnt_onehot = 8'h01.
- Rotation: req = 8'hFF, gnt_ready = 1 continuously -> gnt_idx sequence 0,1,2,…,7,0 with a grant every cycle; ptr trails gnt_idx by one handshake.
- Wrap: drive grants until ptr = 6, then req = 8'b0010_0001 -> gnt_idx = 0 (scan order 6,7,0). After the handshake ptr = 1 and the next grant is idx 5.
- Backpressure: in HOLD with gnt_idx = 3, gnt_ready = 0 for 3 cycles while req toggles 8'hF0/8'h00 -> gnt_idx = 3 and ptr stay constant. Raise gnt_ready -> ptr = 4.
- Sole requester: req = 8'h10, gnt_ready = 1 -> gnt_valid pattern 1,0,1,0, gnt_idx = 4 on each valid cycle, ptr = 5 after the first handshake.
- Flush: in HOLD with gnt_idx = 2, assert flush and gnt_ready together -> next cycle gnt_valid = 0, gnt_onehot = 0, ptr unchanged. With req = 8'h04 still high, the grant returns one cycle later.
